ball_bounce_ctrl: RTL and testbench

- Collision and direction controller sitting directly upstream of the ball position counters.
- Produces the vertical direction bit consumed by the vertical ball counter, and the horizontal equivalent for the horizontal counter.
- Watches the composed ball and paddle video each frame and latches wall and paddle hits. At the start of vertical blank it commits new directions and detects misses.
- Runs the serve/score sequencing that gates the ball on and off.

---
 rtl/ball_bounce_ctrl_pkg.sv | 56 +++++
 rtl/ball_bounce_ctrl_edge_detect.sv | 20 ++
 rtl/ball_bounce_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ball_bounce_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_bounce_ctrl_pkg.sv
// Shared definitions for the ball collision/direction controller:
// FSM encodings, the per-frame hit record and the commit-time resolution rule.
package ball_bounce_ctrl_pkg;

   localparam logic [1:0] ST_SERVE = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;
   localparam logic [1:0] ST_SCORE = 2'd3;

   typedef struct packed {
      logic top;
      logic bot;
      logic left;
      logic right;
      logic p1;
      logic p2;
   } hit_flags_t;

   typedef struct packed {
      logic vdir;
      logic hdir;
      logic score1;
      logic score2;
   } commit_t;

   // Opposing hits cancel; an edge hit only counts as a miss without the
   // matching paddle hit, and a double miss awards player 2.
   function automatic commit_t resolve_hits(input hit_flags_t hits,
                                            input logic       vdir,
                                            input logic       hdir);
      commit_t res;
      res.vdir   = vdir;
      res.hdir   = hdir;
      res.score1 = 1'b0;
      res.score2 = 1'b0;
      if (hits.top && !hits.bot) begin
         res.vdir = 1'b0;
      end else if (hits.bot && !hits.top) begin
         res.vdir = 1'b1;
      end
      if (hits.p1 && !hits.p2) begin
         res.hdir = 1'b0;
      end else if (hits.p2 && !hits.p1) begin
         res.hdir = 1'b1;
      end
      if (hits.left && !hits.p1) begin
         res.score2 = 1'b1;
         res.hdir   = 1'b1;
      end else if (hits.right && !hits.p2) begin
         res.score1 = 1'b1;
         res.hdir   = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/ball_bounce_ctrl_edge_detect.sv
// Registers one level and reports its rising and falling edges in the first
// cycle the new level is present.
module ball_bounce_ctrl_edge_detect (
   input  logic clk,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic level_q;

   // No reset: tracking the input through reset means no false edge on exit.
   always_ff @(posedge clk) begin
      level_q <= level;
   end

   assign rise = level & ~level_q;
   assign fall = ~level & level_q;

endmodule

// File: rtl/ball_bounce_ctrl.sv
// Collision and direction controller feeding the ball position counters:
// latches wall/paddle hits per frame, commits directions at vertical blank, runs serve/score.
module ball_bounce_ctrl #(
   parameter int p_AUTO_SERVE_FRAMES = 0,
   parameter int p_FRAME_CNT_BITS    = 8
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_HBlank,
   input  logic       i_VBlank,
   input  logic       i_HReset,
   input  logic       i_BallVideo,
   input  logic       i_Paddle1Video,
   input  logic       i_Paddle2Video,
   input  logic       i_Serve,
   output logic       o_VDir,
   output logic       o_HDir,
   output logic       o_BallEnable,
   output logic       o_Score1,
   output logic       o_Score2,
   output logic [1:0] dbg_state
);
   import ball_bounce_ctrl_pkg::*;

   localparam bit AUTO_EN = (p_AUTO_SERVE_FRAMES > 0);
   localparam logic [p_FRAME_CNT_BITS-1:0] FRAME_LAST =
      p_FRAME_CNT_BITS'(AUTO_EN ? p_AUTO_SERVE_FRAMES - 1 : 0);

   logic                        hb_rise, hb_fall;
   logic                        vb_rise, vb_fall;
   logic [1:0]                  state;
   logic [p_FRAME_CNT_BITS-1:0] frame_cnt;
   hit_flags_t                  hits, hits_next;
   commit_t                     res;
   logic                        ball_vis, ball_q;
   logic                        top_pending, line_seen;
   logic                        commit_q, commit, in_play;

   ball_bounce_ctrl_edge_detect u_hblank_edge (
      .clk   (i_Clk),
      .level (i_HBlank),
      .rise  (hb_rise),
      .fall  (hb_fall)
   );

   ball_bounce_ctrl_edge_detect u_vblank_edge (
      .clk   (i_Clk),
      .level (i_VBlank),
      .rise  (vb_rise),
      .fall  (vb_fall)
   );

   assign ball_vis  = i_BallVideo & ~i_HBlank & ~i_VBlank;
   assign in_play   = (state == ST_PLAY);
   assign commit    = commit_q & in_play;
   assign res       = resolve_hits(hits, o_VDir, o_HDir);
   assign dbg_state = state;

   // Right column and bottom line are only known once blank starts, so they
   // are judged from the previous pixel / previous line.
   always_comb begin
      hits_next = hits;
      if (in_play) begin
         if (ball_vis && top_pending) begin
            hits_next.top = 1'b1;
         end
         if (vb_rise && line_seen) begin
            hits_next.bot = 1'b1;
         end
         if (ball_vis && hb_fall) begin
            hits_next.left = 1'b1;
         end
         if (hb_rise && ball_q) begin
            hits_next.right = 1'b1;
         end
         if (i_BallVideo && i_Paddle1Video && !i_VBlank) begin
            hits_next.p1 = 1'b1;
         end
         if (i_BallVideo && i_Paddle2Video && !i_VBlank) begin
            hits_next.p2 = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         ball_q      <= 1'b0;
         commit_q    <= 1'b0;
         top_pending <= 1'b0;
         line_seen   <= 1'b0;
         hits        <= '0;
      end else begin
         ball_q   <= ball_vis;
         commit_q <= vb_rise;
         // Set wins: VBlank falls in the same cycle as the previous line's HBlank rise.
         if (vb_fall) begin
            top_pending <= 1'b1;
         end else if (hb_rise) begin
            top_pending <= 1'b0;
         end
         if (i_HReset) begin
            line_seen <= 1'b0;
         end else if (ball_vis) begin
            line_seen <= 1'b1;
         end
         hits <= (in_play && !commit) ? hits_next : '0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state        <= ST_SERVE;
         frame_cnt    <= '0;
         o_VDir       <= 1'b0;
         o_HDir       <= 1'b0;
         o_BallEnable <= 1'b0;
         o_Score1     <= 1'b0;
         o_Score2     <= 1'b0;
      end else begin
         o_Score1 <= 1'b0;
         o_Score2 <= 1'b0;
         case (state)
            ST_SERVE: begin
               o_BallEnable <= 1'b0;
               if (i_Serve) begin
                  state     <= ST_ARMED;
                  frame_cnt <= '0;
               end else if (AUTO_EN && vb_rise) begin
                  if (frame_cnt == FRAME_LAST) begin
                     state     <= ST_ARMED;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            ST_ARMED: begin
               frame_cnt    <= '0;
               o_BallEnable <= 1'b0;
               if (vb_rise) begin
                  state        <= ST_PLAY;
                  o_BallEnable <= 1'b1;
               end
            end
            ST_PLAY: begin
               o_BallEnable <= 1'b1;
               if (commit) begin
                  o_VDir <= res.vdir;
                  o_HDir <= res.hdir;
                  // Score outputs, serve direction and ball-off all land with the SCORE cycle.
                  if (res.score1 || res.score2) begin
                     state        <= ST_SCORE;
                     o_BallEnable <= 1'b0;
                     o_Score1     <= res.score1;
                     o_Score2     <= res.score2;
                  end
               end
            end
            ST_SCORE: begin
               o_BallEnable <= 1'b0;
               state        <= ST_SERVE;
            end
            default: begin
               o_BallEnable <= 1'b0;
               state        <= ST_SERVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Randomized frame-level stimulus for ball_bounce_ctrl, checked against a
// rectangle-geometry reference model through an expected-result queue.
module tb_ball_bounce_ctrl;

   localparam int H_BLANK  = 4;
   localparam int H_VIS    = 16;
   localparam int V_VIS    = 10;
   localparam int V_BLANK  = 2;
   localparam int AUTO     = 3;
   localparam int PW       = 2;
   localparam int PH       = 4;
   localparam int N_FRAMES = 120;
   localparam int W        = 7;

   logic       i_Clk;
   logic       i_Reset, i_HBlank, i_VBlank, i_HReset;
   logic       i_BallVideo, i_Paddle1Video, i_Paddle2Video, i_Serve;
   logic       o_VDir, o_HDir, o_BallEnable, o_Score1, o_Score2;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   typedef enum int {M_SERVE, M_ARMED, M_PLAY} mstate_t;
   mstate_t m_st;
   int      m_cnt;
   bit      m_vdir, m_hdir, m_en;
   int      bx, by, bw, bh, p1y, p2y;

   // ---------------- clock / reset ----------------
   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   ball_bounce_ctrl #(
      .p_AUTO_SERVE_FRAMES (AUTO),
      .p_FRAME_CNT_BITS    (4)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Reset        (i_Reset),
      .i_HBlank       (i_HBlank),
      .i_VBlank       (i_VBlank),
      .i_HReset       (i_HReset),
      .i_BallVideo    (i_BallVideo),
      .i_Paddle1Video (i_Paddle1Video),
      .i_Paddle2Video (i_Paddle2Video),
      .i_Serve        (i_Serve),
      .o_VDir         (o_VDir),
      .o_HDir         (o_HDir),
      .o_BallEnable   (o_BallEnable),
      .o_Score1       (o_Score1),
      .o_Score2       (o_Score2),
      .dbg_state      (dbg_state)
   );

   // ---------------- helpers ----------------
   task automatic cycle();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic bit overlap(input int a0, input int alen, input int b0, input int blen);
      return (a0 < b0 + blen) && (b0 < a0 + alen);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_vdir"},  o_VDir,       0);
      check({tag, "_hdir"},  o_HDir,       0);
      check({tag, "_en"},    o_BallEnable, 0);
      check({tag, "_s1"},    o_Score1,     0);
      check({tag, "_s2"},    o_Score2,     0);
      check({tag, "_state"}, dbg_state,    0);
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_st   = M_SERVE;
      m_cnt  = 0;
      m_vdir = 0;
      m_hdir = 0;
      m_en   = 0;
   endtask

   task automatic apply_serve();
      if (m_st == M_SERVE && i_Serve) begin
         m_st  = M_ARMED;
         m_cnt = 0;
      end
   endtask

   // Called at the VBlank rise: evaluates the finished frame, takes the next
   // period's serve level, and queues the outputs expected two cycles later.
   task automatic model_rise(input bit new_serve);
      bit top, bot, left, right, hp1, hp2, s1, s2;
      logic [1:0] st_code;
      s1 = 0;
      s2 = 0;
      case (m_st)
         M_SERVE: begin
            m_cnt++;
            if (AUTO > 0 && m_cnt == AUTO) begin
               m_st  = M_ARMED;
               m_cnt = 0;
            end
         end
         M_ARMED: begin
            m_st = M_PLAY;
            m_en = 1;
         end
         default: begin
            top   = (by == 0);
            bot   = (by + bh == V_VIS);
            left  = (bx == 0);
            right = (bx + bw == H_VIS);
            hp1   = overlap(bx, bw, 0, PW) && overlap(by, bh, p1y, PH);
            hp2   = overlap(bx, bw, H_VIS - PW, PW) && overlap(by, bh, p2y, PH);
            if (top && !bot) m_vdir = 0;
            if (bot && !top) m_vdir = 1;
            if (hp1 && !hp2) m_hdir = 0;
            if (hp2 && !hp1) m_hdir = 1;
            if (left && !hp1) begin
               s2 = 1;
               m_hdir = 1;
            end else if (right && !hp2) begin
               s1 = 1;
               m_hdir = 0;
            end
            if (s1 || s2) begin
               m_st = M_SERVE;
               m_en = 0;
            end
         end
      endcase
      i_Serve = new_serve;
      apply_serve();
      if (s1 || s2)              st_code = 2'd3;
      else if (m_st == M_SERVE)  st_code = 2'd0;
      else if (m_st == M_ARMED)  st_code = 2'd1;
      else                       st_code = 2'd2;
      exp_q.push_back({st_code, m_vdir, m_hdir, m_en, s1, s2});
   endtask

   // ---------------- driver ----------------
   task automatic run_frame(input int rst_line);
      bw = ($urandom_range(0, 7) == 0) ? H_VIS : $urandom_range(1, 3);
      bh = ($urandom_range(0, 7) == 0) ? V_VIS : $urandom_range(1, 3);
      case ($urandom_range(0, 3))
         0:       bx = 0;
         1:       bx = H_VIS - bw;
         default: bx = $urandom_range(0, H_VIS - bw);
      endcase
      case ($urandom_range(0, 3))
         0:       by = 0;
         1:       by = V_VIS - bh;
         default: by = $urandom_range(0, V_VIS - bh);
      endcase
      p1y = $urandom_range(0, V_VIS - PH);
      p2y = $urandom_range(0, V_VIS - PH);
      for (int l = 0; l < V_VIS + V_BLANK; l++) begin
         for (int c = 0; c < H_BLANK + H_VIS; c++) begin
            int x;
            bit vis;
            x   = c - H_BLANK;
            vis = (l < V_VIS) && (c >= H_BLANK);
            if (l == V_VIS && c == 0) begin
               model_rise($urandom_range(0, 2) == 0);
            end
            i_VBlank       = (l >= V_VIS);
            i_HBlank       = (c < H_BLANK);
            i_HReset       = (c == 0);
            i_BallVideo    = vis && x >= bx && x < bx + bw && l >= by && l < by + bh;
            i_Paddle1Video = vis && x < PW && l >= p1y && l < p1y + PH;
            i_Paddle2Video = vis && x >= H_VIS - PW && l >= p2y && l < p2y + PH;
            i_Reset        = (l == rst_line && c == H_BLANK + 2);
            cycle();
            if (i_Reset) begin
               #2;
               check_reset_outputs("midframe_reset");
               model_reset();
               apply_serve();
            end
         end
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic         vb_prev;
      int           pend;
      int           n;
      logic [W-1:0] got;
      logic [W-1:0] want;
      vb_prev = 1'b1;
      pend    = 0;
      n       = 0;
      forever begin
         @(negedge i_Clk);
         if (pend == 1) begin
            got = {dbg_state, o_VDir, o_HDir, o_BallEnable, o_Score1, o_Score2};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL commit_%0d no expected entry, got state/vdir/hdir/en/s1/s2=%b", n, got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL commit_%0d state/vdir/hdir/en/s1/s2 got %b expected %b", n, got, want);
               end
            end
            n++;
         end else begin
            checks++;
            if ({o_Score1, o_Score2} !== 2'b00) begin
               errors++;
               $display("FAIL idle_score got s1/s2=%b%b expected 00 at %0t", o_Score1, o_Score2, $time);
            end
         end
         if (pend > 0) pend--;
         if (i_VBlank === 1'b1 && vb_prev === 1'b0) pend = 2;
         vb_prev = i_VBlank;
      end
   end

   // ---------------- main sequence and report ----------------
   initial begin : main
      int rst_a, rst_b;
      i_Reset        = 1'b1;
      i_HBlank       = 1'b1;
      i_VBlank       = 1'b1;
      i_HReset       = 1'b0;
      i_BallVideo    = 1'b0;
      i_Paddle1Video = 1'b0;
      i_Paddle2Video = 1'b0;
      i_Serve        = 1'b0;
      repeat (3) cycle();
      #2;
      check_reset_outputs("reset");
      i_Reset = 1'b0;
      i_Serve = ($urandom_range(0, 2) == 0);
      model_reset();
      apply_serve();
      rst_a = 40 + $urandom_range(0, 5);
      rst_b = 85 + $urandom_range(0, 5);
      for (int f = 0; f < N_FRAMES; f++) begin
         if (f == rst_a || f == rst_b) run_frame($urandom_range(1, V_VIS - 1));
         else                          run_frame(-1);
      end
      repeat (5) cycle();
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
